// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store request, load-hit and memory drain signals of store_buffer
//
// Purpose : bundles the core-side store handshake, the load-hit probe, the
//           drain control and the word-wide memory write port.
// Modports: slave  - the store buffer itself
//           master - the core / memory side that drives and observes it
// Signals : st_valid/st_ready/st_funct3/st_addr/st_data/st_err - store request
//           drain                                              - block new stores
//           ld_addr/ld_hit                                     - pending-store probe
//           mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb   - memory write
//           count/empty                                        - occupancy
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic          st_ready;
    logic [2:0]    st_funct3;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic          st_err;
    logic          drain;
    logic [31:0]   ld_addr;
    logic          ld_hit;
    logic          mem_valid;
    logic          mem_ready;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [CW-1:0] count;
    logic          empty;

    modport slave (
        input  st_valid, st_funct3, st_addr, st_data, drain, ld_addr, mem_ready,
        output st_ready, st_err, ld_hit, mem_valid, mem_addr, mem_wdata, mem_wstrb,
               count, empty
    );

    modport master (
        output st_valid, st_funct3, st_addr, st_data, drain, ld_addr, mem_ready,
        input  st_ready, st_err, ld_hit, mem_valid, mem_addr, mem_wdata, mem_wstrb,
               count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - byte-lane aligning store FIFO between core and data memory
//
// Purpose : accepts sb/sh/sw requests, aligns data onto byte lanes with
//           write strobes, queues them in a DEPTH-entry circular buffer and
//           drains the head entry to a byte-strobed memory over valid/ready.
//           A word-address probe reports loads that hit a pending store.
// Ports   : clk   - rising-edge clock
//           reset - synchronous active-low reset
//           bus   - store_buffer_if.slave (store request, drain, load probe,
//                   memory write port, count/empty)
// Config  : STORE_BUF_MISALIGN_CHECK_EN - when defined, misaligned sh/sw are
//           accepted but discarded with an st_err pulse; when undefined they
//           are aligned down and queued.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Queue state
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_st_err;

    // Entry storage; deliberately not reset, occupancy is tracked by r_count
    logic [29:0]   r_ent_addr  [DEPTH];
    logic [31:0]   r_ent_wdata [DEPTH];
    logic [3:0]    r_ent_wstrb [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_st_ready;
    logic          w_accept;
    logic          w_enq;
    logic          w_deq;
    logic          w_bad;
    logic          w_misalign_h;
    logic          w_misalign_w;
    logic [31:0]   w_wdata;
    logic [3:0]    w_wstrb;
    logic [DEPTH-1:0] w_ent_valid;
    logic          w_ld_hit;
    logic          w_unused;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);

    // A full buffer refuses new stores even if the head leaves this cycle;
    // this keeps st_ready independent of mem_ready.
    assign w_st_ready = reset & ~w_full & ~bus.drain;
    assign w_accept   = bus.st_valid & w_st_ready;
    assign w_enq      = w_accept & ~w_bad;
    assign w_deq      = ~w_empty & bus.mem_ready;

`ifdef STORE_BUF_MISALIGN_CHECK_EN
    assign w_misalign_h = bus.st_addr[0];
    assign w_misalign_w = (bus.st_addr[1:0] != 2'b00);
`else
    assign w_misalign_h = 1'b0;
    assign w_misalign_w = 1'b0;
`endif

    // Lane alignment of the incoming request. Data is replicated across all
    // lanes so the strobe alone selects which bytes memory takes.
    always_comb begin
        w_wdata = bus.st_data;
        w_wstrb = 4'b1111;
        w_bad   = 1'b0;
        case (bus.st_funct3)
            3'b000: begin
                w_wdata = {4{bus.st_data[7:0]}};
                w_wstrb = 4'b0001 << bus.st_addr[1:0];
            end
            3'b001: begin
                w_wdata = {2{bus.st_data[15:0]}};
                w_wstrb = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                w_bad   = w_misalign_h;
            end
            3'b010: begin
                w_wdata = bus.st_data;
                w_wstrb = 4'b1111;
                w_bad   = w_misalign_w;
            end
            default: begin
                w_bad   = 1'b1;
            end
        endcase
    end

    // Pointers, occupancy and error pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_st_err <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap
            if (w_enq) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_st_err <= w_accept & w_bad;
        end
    end

    // Entry write; w_enq is already gated by reset through st_ready
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_ent_addr[r_wptr]  <= bus.st_addr[31:2];
            r_ent_wdata[r_wptr] <= w_wdata;
            r_ent_wstrb[r_wptr] <= w_wstrb;
        end
    end

    // An entry is live when its distance from the head is below count
    always_comb begin
        w_ent_valid = '0;
        w_ld_hit    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ent_valid[i] = (CW'(AW'(i) - r_rptr) < r_count);
            if (w_ent_valid[i] && (r_ent_addr[i] == bus.ld_addr[31:2])) begin
                w_ld_hit = 1'b1;
            end
        end
    end

    // Byte offset of the load address is irrelevant to a word match
    assign w_unused      = ^bus.ld_addr[1:0];

    assign bus.st_ready  = w_st_ready;
    assign bus.st_err    = r_st_err;
    assign bus.ld_hit    = w_ld_hit;
    assign bus.mem_valid = ~w_empty;
    assign bus.mem_addr  = {r_ent_addr[r_rptr], 2'b00};
    assign bus.mem_wdata = r_ent_wdata[r_rptr];
    assign bus.mem_wstrb = r_ent_wstrb[r_rptr];
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } ent_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   chk_on;
    logic exp_err;
    ent_t mq[$];
    ent_t drained[$];

    store_buffer_if #(.DEPTH(DEPTH)) sb_if ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    endfunction

    function automatic bit is_bad(input logic [2:0] f3, input logic [31:0] a);
        if (f3 > 3'd2) return 1'b1;
`ifdef STORE_BUF_MISALIGN_CHECK_EN
        if ((int'(a[1:0]) % size_bytes(f3)) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Byte-lane view: the access of n bytes lands on the naturally aligned
    // n-byte group containing the address; every lane carries data byte (b mod n).
    function automatic ent_t align(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        int n;
        int off;
        n = size_bytes(f3);
        off = (int'(a[1:0]) / n) * n;
        e.addr  = {a[31:2], 2'b00};
        e.wdata = '0;
        e.wstrb = '0;
        for (int b = 0; b < 4; b++) e.wdata[8*b +: 8] = d[8*(b % n) +: 8];
        for (int b = off; b < off + n; b++) e.wstrb[b] = 1'b1;
        return e;
    endfunction

    // Reference model: a queue of aligned entries updated at each rising edge
    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            exp_err = 1'b0;
        end else begin
            bit acc;
            bit deq;
            acc = sb_if.st_valid && (mq.size() < DEPTH) && !sb_if.drain;
            deq = (mq.size() > 0) && sb_if.mem_ready;
            if (deq) drained.push_back(mq.pop_front());
            exp_err = acc && is_bad(sb_if.st_funct3, sb_if.st_addr);
            if (acc && !is_bad(sb_if.st_funct3, sb_if.st_addr))
                mq.push_back(align(sb_if.st_funct3, sb_if.st_addr, sb_if.st_data));
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            logic hit;
            hit = 1'b0;
            foreach (mq[k]) if (mq[k].addr[31:2] == sb_if.ld_addr[31:2]) hit = 1'b1;
            chk("cyc_st_ready", 32'(sb_if.st_ready), 32'(reset && (mq.size() < DEPTH) && !sb_if.drain));
            chk("cyc_mem_valid", 32'(sb_if.mem_valid), 32'(mq.size() != 0));
            chk("cyc_count", 32'(sb_if.count), 32'(mq.size()));
            chk("cyc_empty", 32'(sb_if.empty), 32'(mq.size() == 0));
            chk("cyc_st_err", 32'(sb_if.st_err), 32'(exp_err));
            chk("cyc_ld_hit", 32'(sb_if.ld_hit), 32'(hit));
            if (mq.size() != 0) begin
                chk("cyc_mem_addr", sb_if.mem_addr, mq[0].addr);
                chk("cyc_mem_wdata", sb_if.mem_wdata, mq[0].wdata);
                chk("cyc_mem_wstrb", 32'(sb_if.mem_wstrb), 32'(mq[0].wstrb));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        sb_if.st_funct3 = f3;
        sb_if.st_addr   = a;
        sb_if.st_data   = d;
        sb_if.st_valid  = 1'b1;
        tick();
        sb_if.st_valid  = 1'b0;
    endtask

    task automatic flush();
        int n;
        n = 0;
        sb_if.mem_ready = 1'b1;
        while (!sb_if.empty && n < 20) begin
            tick();
            n++;
        end
        chk("flush_empty", 32'(sb_if.empty), 32'd1);
    endtask

    initial begin
        int i;
        int cyc;
        bit go;
        checks = 0;
        errors = 0;
        chk_on = 1'b0;
        reset = 1'b0;
        sb_if.st_valid  = 1'b0;
        sb_if.st_funct3 = 3'd0;
        sb_if.st_addr   = '0;
        sb_if.st_data   = '0;
        sb_if.drain     = 1'b0;
        sb_if.ld_addr   = '0;
        sb_if.mem_ready = 1'b0;

        // Reset for two edges
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_count", 32'(sb_if.count), 32'd0);
        chk("rst_empty", 32'(sb_if.empty), 32'd1);
        chk("rst_mem_valid", 32'(sb_if.mem_valid), 32'd0);
        chk("rst_st_ready", 32'(sb_if.st_ready), 32'd0);
        chk("rst_st_err", 32'(sb_if.st_err), 32'd0);
        reset = 1'b1;
        tick();

        // Byte store
        put(3'b000, 32'h66, 32'hA5);
        chk("sb_mem_valid", 32'(sb_if.mem_valid), 32'd1);
        chk("sb_mem_addr", sb_if.mem_addr, 32'h64);
        chk("sb_mem_wdata", sb_if.mem_wdata, 32'hA5A5A5A5);
        chk("sb_mem_wstrb", 32'(sb_if.mem_wstrb), 32'b0100);
        chk("model_sb_wdata", mq[0].wdata, 32'hA5A5A5A5);
        chk("model_sb_wstrb", 32'(mq[0].wstrb), 32'b0100);
        flush();

        // Fill and stall, then ordered drain
        sb_if.mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) put(3'b010, 32'h60 + 32'(4*k), 32'h11111111 * (k + 1));
        chk("fill_count", 32'(sb_if.count), 32'd4);
        chk("fill_st_ready", 32'(sb_if.st_ready), 32'd0);
        sb_if.ld_addr = 32'h6A;
        #1 chk("fill_hit_6a", 32'(sb_if.ld_hit), 32'd1);
        sb_if.ld_addr = 32'h70;
        #1 chk("fill_hit_70", 32'(sb_if.ld_hit), 32'd0);
        sb_if.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_order_addr", sb_if.mem_addr, 32'h60 + 32'(4*k));
            chk("drain_order_data", sb_if.mem_wdata, 32'h11111111 * (k + 1));
            tick();
        end
        chk("drain_empty", 32'(sb_if.empty), 32'd1);

        // Wrap-around: 10 halfword stores with toggling mem_ready
        drained.delete();
        i = 0;
        cyc = 0;
        while (i < 10 && cyc < 200) begin
            sb_if.st_funct3 = 3'b001;
            sb_if.st_addr   = 32'h40 + 32'(2*i);
            sb_if.st_data   = 32'(i);
            sb_if.st_valid  = 1'b1;
            sb_if.mem_ready = cyc[0];
            #1 go = sb_if.st_ready;
            tick();
            if (go) i++;
            cyc++;
        end
        sb_if.st_valid = 1'b0;
        chk("wrap_accept_timeout", 32'(i), 32'd10);
        flush();
        chk("wrap_drained_n", 32'(drained.size()), 32'd10);
        for (int k = 0; k < 10 && k < drained.size(); k++) begin
            chk("wrap_addr", drained[k].addr, 32'h40 + 32'(4*(k/2)));
            chk("wrap_wdata", drained[k].wdata, {16'(k), 16'(k)});
            chk("wrap_wstrb", 32'(drained[k].wstrb), (k % 2) ? 32'b1100 : 32'b0011);
        end

        // Simultaneous enqueue and dequeue at count 2
        sb_if.mem_ready = 1'b0;
        put(3'b010, 32'h90, 32'hAAAA0001);
        put(3'b010, 32'h94, 32'hAAAA0002);
        chk("sim_count_pre", 32'(sb_if.count), 32'd2);
        sb_if.mem_ready = 1'b1;
        put(3'b010, 32'h98, 32'hAAAA0003);
        chk("sim_count", 32'(sb_if.count), 32'd2);
        chk("sim_head", sb_if.mem_addr, 32'h94);
        flush();

        // Full buffer with mem_ready high refuses the store
        sb_if.mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) put(3'b010, 32'hA0 + 32'(4*k), 32'(k));
        sb_if.mem_ready = 1'b1;
        sb_if.st_funct3 = 3'b010;
        sb_if.st_addr   = 32'hC0;
        sb_if.st_valid  = 1'b1;
        #1 chk("full_st_ready", 32'(sb_if.st_ready), 32'd0);
        tick();
        sb_if.st_valid = 1'b0;
        chk("full_count", 32'(sb_if.count), 32'd3);
        flush();

        // Drain input blocks acceptance
        sb_if.mem_ready = 1'b0;
        put(3'b010, 32'hB0, 32'h5);
        sb_if.drain = 1'b1;
        sb_if.st_valid = 1'b1;
        #1 chk("drain_st_ready", 32'(sb_if.st_ready), 32'd0);
        tick();
        chk("drain_count", 32'(sb_if.count), 32'd1);
        sb_if.st_valid = 1'b0;
        flush();
        sb_if.drain = 1'b0;

        // Invalid funct3
        put(3'b011, 32'h20, 32'h1);
        chk("err_pulse", 32'(sb_if.st_err), 32'd1);
        chk("err_count", 32'(sb_if.count), 32'd0);
        tick();
        chk("err_low", 32'(sb_if.st_err), 32'd0);

        // Misaligned word
        put(3'b010, 32'h62, 32'h12345678);
`ifdef STORE_BUF_MISALIGN_CHECK_EN
        chk("mis_err", 32'(sb_if.st_err), 32'd1);
        chk("mis_count", 32'(sb_if.count), 32'd0);
`else
        chk("mis_err", 32'(sb_if.st_err), 32'd0);
        chk("mis_addr", sb_if.mem_addr, 32'h60);
        chk("mis_wstrb", 32'(sb_if.mem_wstrb), 32'b1111);
`endif
        flush();

        // Reset mid-operation
        sb_if.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) put(3'b010, 32'h200 + 32'(4*k), 32'(k));
        chk("mid_mem_valid_pre", 32'(sb_if.mem_valid), 32'd1);
        sb_if.ld_addr = 32'h204;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("mid_count", 32'(sb_if.count), 32'd0);
        chk("mid_mem_valid", 32'(sb_if.mem_valid), 32'd0);
        chk("mid_ld_hit", 32'(sb_if.ld_hit), 32'd0);
        tick();
        tick();

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
